bcd_counter_mux: RTL and testbench

Parametrised multi-digit BCD counter with time-multiplexed seven-segment drive. It counts up or down, loads in parallel, and flags wrap-around with a terminal-count pulse. A scan engine cycles through the digits and drives one segment bus plus one-hot digit selects. It sits between the board-level control inputs and the seven-segment display, and replaces the single-digit BCD counter in display paths that need several digits.

---
 rtl/bcd_counter_mux.sv | 173 +++++++++++++++++
 tb/tb_bcd_counter_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_mux.sv
// Multi-digit BCD up/down counter with parallel load, terminal-count and
// load-error pulses, and a time-multiplexed seven-segment scan driver with
// optional leading-zero blanking.
module bcd_counter_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4,
  parameter int BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  rst_syn,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   Q_out,
  output logic                  tc_out,
  output logic                  load_err,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Seven-segment pattern {dp,g,f,e,d,c,b,a} for a decimal digit.
  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 8'h3F;
      4'd1:    seg_encode = 8'h06;
      4'd2:    seg_encode = 8'h5B;
      4'd3:    seg_encode = 8'h4F;
      4'd4:    seg_encode = 8'h66;
      4'd5:    seg_encode = 8'h6D;
      4'd6:    seg_encode = 8'h7D;
      4'd7:    seg_encode = 8'h07;
      4'd8:    seg_encode = 8'h7F;
      4'd9:    seg_encode = 8'h6F;
      default: seg_encode = 8'h00;
    endcase
  endfunction

  // A loaded nibble outside 0..9 is replaced by 0.
  function automatic logic [3:0] sanitize_digit(input logic [3:0] d);
    sanitize_digit = (d > 4'd9) ? 4'd0 : d;
  endfunction

  logic [4*DIGITS-1:0] r_q;
  logic                r_tc;
  logic                r_lerr;
  logic [PRE_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS-1:0]   r_sel;
  logic [7:0]          r_seg;

  logic [4*DIGITS-1:0] w_q_next;
  logic                w_tc_next;
  logic                w_lerr_next;
  logic                w_carry;
  logic [3:0]          w_dig;
  logic                w_pre_tc;
  logic [DIGITS-1:0]   w_blank;
  logic [3:0]          w_cur_dig;
  logic                w_cur_blank;
  logic [DIGITS-1:0]   w_sel_next;

  assign Q_out    = r_q;
  assign tc_out   = r_tc;
  assign load_err = r_lerr;
  assign seg_out  = r_seg;
  assign dig_sel  = r_sel;

  // Next count value: load beats count; the carry/borrow ripples from digit 0
  // upward and a carry out of the top digit is the wrap-around event.
  always_comb begin
    w_q_next    = r_q;
    w_tc_next   = 1'b0;
    w_lerr_next = 1'b0;
    w_carry     = 1'b1;
    w_dig       = 4'd0;
    if (load) begin
      for (int k = 0; k < DIGITS; k++) begin
        w_dig = data[4*k +: 4];
        w_q_next[4*k +: 4] = sanitize_digit(w_dig);
        if (w_dig > 4'd9) w_lerr_next = 1'b1;
      end
    end else if (en) begin
      for (int k = 0; k < DIGITS; k++) begin
        w_dig = r_q[4*k +: 4];
        if (w_carry) begin
          if (up) begin
            if (w_dig == 4'd9) begin
              w_q_next[4*k +: 4] = 4'd0;
            end else begin
              w_q_next[4*k +: 4] = w_dig + 4'd1;
              w_carry = 1'b0;
            end
          end else begin
            if (w_dig == 4'd0) begin
              w_q_next[4*k +: 4] = 4'd9;
            end else begin
              w_q_next[4*k +: 4] = w_dig - 4'd1;
              w_carry = 1'b0;
            end
          end
        end
      end
      w_tc_next = w_carry;
    end
  end

  // Counter state and its one-cycle status pulses.
  always_ff @(posedge clk or posedge rst_syn) begin
    if (rst_syn) begin
      r_q    <= '0;
      r_tc   <= 1'b0;
      r_lerr <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_tc   <= w_tc_next;
      r_lerr <= w_lerr_next;
    end
  end

  assign w_pre_tc = (r_pre == PRE_W'(SCAN_DIV - 1));

  // Free-running scan: prescaler terminal value steps to the next digit.
  always_ff @(posedge clk or posedge rst_syn) begin
    if (rst_syn) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_pre_tc) begin
      r_pre <= '0;
      if (r_idx == IDX_W'(DIGITS - 1)) r_idx <= '0;
      else                             r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Digit k>0 is a leading zero when every bit from digit k upward is zero.
  always_comb begin
    w_blank = '0;
    for (int k = 1; k < DIGITS; k++) begin
      w_blank[k] = (BLANK != 0) && ((r_q >> (4*k)) == '0);
    end
  end

  // Select the digit currently addressed by the scan index.
  always_comb begin
    w_cur_dig   = r_q[3:0];
    w_cur_blank = 1'b0;
    w_sel_next  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_cur_dig     = r_q[4*k +: 4];
        w_cur_blank   = w_blank[k];
        w_sel_next[k] = 1'b1;
      end
    end
  end

  // Display registers: segment bus and digit select stay aligned to one digit.
  always_ff @(posedge clk or posedge rst_syn) begin
    if (rst_syn) begin
      r_sel <= DIGITS'(1);
      r_seg <= 8'h3F;
    end else begin
      r_sel <= w_sel_next;
      r_seg <= w_cur_blank ? 8'h00 : seg_encode(w_cur_dig);
    end
  end

endmodule

// File: tb/tb_bcd_counter_mux.sv
// Bench for bcd_counter_mux: directed scenarios plus randomized traffic,
// compared against an integer-valued reference model of the counter and scan.
module tb_bcd_counter_mux;

  localparam int D = 2;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_syn, en, up, load;
  logic [4*D-1:0] data;
  logic [4*D-1:0] q_a, q_b;
  logic         tc_a, tc_b, le_a, le_b;
  logic [7:0]   seg_a, seg_b;
  logic [D-1:0] sel_a, sel_b;

  bcd_counter_mux #(.DIGITS(D), .SCAN_DIV(S), .BLANK(1)) dut_blank (
    .clk(clk), .rst_syn(rst_syn), .en(en), .up(up), .load(load), .data(data),
    .Q_out(q_a), .tc_out(tc_a), .load_err(le_a), .seg_out(seg_a), .dig_sel(sel_a));

  bcd_counter_mux #(.DIGITS(D), .SCAN_DIV(S), .BLANK(0)) dut_noblank (
    .clk(clk), .rst_syn(rst_syn), .en(en), .up(up), .load(load), .data(data),
    .Q_out(q_b), .tc_out(tc_b), .load_err(le_b), .seg_out(seg_b), .dig_sel(sel_b));

  int checks = 0;
  int errors = 0;

  // Reference model: count held as a plain integer 0..10^D-1.
  int m_val, m_prev_val, m_prev_idx, m_n;
  int m_tc, m_le;

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r = '0;
    for (int k = 0; k < D; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [7:0] enc(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
      8: return 8'h7F; default: return 8'h6F;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int idx, input int blank);
    if (blank != 0 && idx > 0 && v < pow10(idx)) return 8'h00;
    return enc((v / pow10(idx)) % 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_prev_val = 0; m_prev_idx = 0; m_n = 0; m_tc = 0; m_le = 0;
  endtask

  task automatic model_edge();
    int nv, dg;
    m_prev_val = m_val;
    m_prev_idx = (m_n / S) % D;
    m_n++;
    m_tc = 0;
    m_le = 0;
    if (load) begin
      nv = 0;
      for (int k = 0; k < D; k++) begin
        dg = int'(data[4*k +: 4]);
        if (dg > 9) begin m_le = 1; dg = 0; end
        nv += dg * pow10(k);
      end
      m_val = nv;
    end else if (en) begin
      if (up) begin
        if (m_val == pow10(D) - 1) begin m_val = 0; m_tc = 1; end
        else m_val++;
      end else begin
        if (m_val == 0) begin m_val = pow10(D) - 1; m_tc = 1; end
        else m_val--;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},     32'(q_a),   32'(to_bcd(m_val)));
    check({tag, ".tc"},    32'(tc_a),  32'(m_tc));
    check({tag, ".lerr"},  32'(le_a),  32'(m_le));
    check({tag, ".sel"},   32'(sel_a), 32'(1) << m_prev_idx);
    check({tag, ".seg"},   32'(seg_a), 32'(exp_seg(m_prev_val, m_prev_idx, 1)));
    check({tag, ".seg_nb"},32'(seg_b), 32'(exp_seg(m_prev_val, m_prev_idx, 0)));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_syn = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst_syn = 1'b0;

    // Idle scan with blanking of the upper zero digit.
    for (int i = 0; i < 8; i++) tick("idle");

    // Load 98, then count up through the wrap.
    load = 1'b1; data = 8'h98;
    tick("ld98");
    check("ld98.lit", 32'(q_a), 32'h98);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick("up99");
    tick("up00");
    check("wrap_up.q", 32'(q_a), 32'h00);
    check("wrap_up.tc", 32'(tc_a), 32'd1);

    // Count down from 00 through the wrap.
    up = 1'b0;
    tick("dn99");
    check("wrap_dn.q", 32'(q_a), 32'h99);
    check("wrap_dn.tc", 32'(tc_a), 32'd1);
    tick("dn98");
    check("dn98.tc", 32'(tc_a), 32'd0);

    // Borrow across digits: 10 -> 09.
    en = 1'b0; load = 1'b1; data = 8'h10;
    tick("ld10");
    load = 1'b0; en = 1'b1;
    tick("dn09");
    check("borrow.q", 32'(q_a), 32'h09);

    // Invalid digit in load.
    en = 1'b0; load = 1'b1; data = 8'h5C;
    tick("ld5C");
    check("ld5C.q", 32'(q_a), 32'h50);
    check("ld5C.lerr", 32'(le_a), 32'd1);
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick("show50");

    // Load and enable together: load wins.
    load = 1'b1; en = 1'b1; up = 1'b1; data = 8'h42;
    tick("ld42en");
    check("ld42.q", 32'(q_a), 32'h42);
    check("ld42.tc", 32'(tc_a), 32'd0);

    // Asynchronous reset between edges while counting.
    load = 1'b0; en = 1'b1;
    #2;
    rst_syn = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_syn = 1'b0;
    en = 1'b0;

    // No-blank instance shows the leading zero.
    load = 1'b1; data = 8'h05;
    tick("ld05");
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick("show05");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       data = 8'h99;
        1:       data = 8'h00;
        default: data = 8'($urandom);
      endcase
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
